ship_cursor_ctrl: RTL
=====================

# ship_cursor_ctrl

Parametrised ship-placement cursor for the battleship VGA path. It turns four push-button inputs into a ship anchor position and an orientation, and drives the packed per-cell coordinate bus read by the embarcacao drawing modules. It replaces the fixed-size, button-clocked submarine test cursor with a design that is clock-synchronous, edge-detected, size-generic and bounds-aware. It also adds rotation and a placement lock.

## Interface
- GRID_W, 10: board columns, valid range 1..2^COORD_W-1.
- GRID_H, 10: board rows, valid range 1..2^COORD_W-1.
- MAX_LEN, 5: maximum ship length, i.e. the number of cell slots on the bus.
- COORD_W, 4: bits per coordinate.
- DEBOUNCE_CYCLES, 16: stable cycles required per button; used only with the debounce macro.
- clk, input, 1: system clock.
- reset, input, 1: reset, asynchronous, active-high.
- btn_x, btn_y, btn_rot, btn_confirm, input, 1 each: raw asynchronous buttons, active-high.
- ship_len, input, 3: requested length. 0 is treated as 1; values above MAX_LEN are treated as MAX_LEN.
- positions, output, 2*COORD_W*MAX_LEN: cell i occupies bits [2*COORD_W*i +: 2*COORD_W], with X in the low COORD_W bits and Y in the high COORD_W bits.
- vertical, output, 1: 0 = horizontal, 1 = vertical.
- placed, output, 1: high while locked in the PLACED state.
- visible, output, 1: high in the EDIT and PLACED states.

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector, giving a one-cycle pulse per press.
- Coordinates are 1-based. The value 0 means "no cell"; the drawing modules ignore cells equal to 0.
- Effective length L = clamp(ship_len). L is latched on the HIDDEN→EDIT transition and held until reset.
- Fit limits: horizontal requires X ≤ GRID_W−L+1 and Y ≤ GRID_H. Vertical requires X ≤ GRID_W and Y ≤ GRID_H−L+1.
- States:
  - HIDDEN (reset state):
    - Any btn_x, btn_y or btn_rot pulse moves to EDIT with anchor (1,1), horizontal. The move itself is not applied.
    - btn_confirm is ignored.
  - EDIT:
    - btn_x: X+1; if X was at the fit limit, X wraps to 1.
    - btn_y: Y+1; if Y was at the fit limit, Y wraps to 1.
    - btn_rot: toggles orientation. If the anchor violates the new limit, the offending coordinate is clamped to that limit.
    - btn_confirm: moves to PLACED.
  - PLACED:
    - btn_x, btn_y and btn_rot are ignored.
    - btn_confirm returns to EDIT with the position unchanged.
- Simultaneous pulses in one cycle are resolved by priority: confirm > rot > x > y. Only one action executes; the others are dropped.
- Cell generation, for i < L: horizontal gives (X+i, Y); vertical gives (X, Y+i). For i ≥ L the cell is 0. In HIDDEN the whole bus is 0.
- Arithmetic is unsigned COORD_W-bit. Because of the fit limits, X+i and Y+i never overflow.

## Timing
- All outputs are registered. Reset values: positions = 0, vertical = 0, placed = 0, visible = 0. The internal anchor resets to (0,0) and the state to HIDDEN.
- Latency without debounce: a button sampled high at clk edge n produces the updated outputs after edge n+2.
- Latency with debounce: the update comes DEBOUNCE_CYCLES edges later than without debounce.
- Asserting reset mid-operation, including in PLACED or during a debounce count, clears all outputs immediately. The synchronizer and debounce counters also clear. A button held high through the release of reset produces no pulse.
- Holding a button produces exactly one action; there is no auto-repeat.

## Configuration
- SHIP_CURSOR_DEBOUNCE_EN defined: each synchronized button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the filtered level changes. Edge detection runs on the filtered level, so glitches shorter than DEBOUNCE_CYCLES cause no action.
- Not defined: edge detection runs directly on the synchronizer output, and the debounce counters are not synthesized.

## Structure
- Package battleship_pkg holds:
  - the state encoding (HIDDEN, EDIT, PLACED);
  - the orientation constants HORIZ = 0, VERT = 1;
  - the length clamp function.
- Sub-module btn_conditioner (synchronizer, optional debouncer, rising-edge pulse), instantiated four times.
- Cell generation is a generate loop over MAX_LEN registered slots.

## Test plan
Defaults apply (GRID 10×10, MAX_LEN 5, COORD_W 4), no debounce unless stated.
- Reset with ship_len = 3 → positions = 0, visible = 0, placed = 0. Then one btn_x press → visible = 1 and positions[39:0] = 0x00_00_13_12_11.
- From (1,1) horizontal with L = 3: 7 btn_x presses → cells 0x18, 0x19, 0x1A; an 8th press → cells 0x11, 0x12, 0x13.
- Anchor (8,9) horizontal with L = 3, then btn_rot → vertical = 1, Y clamped to 8, cells 0x88, 0x98, 0xA8.
- btn_confirm and btn_x pulsed in the same cycle → placed = 1 and X unchanged. A following btn_x has no effect. A second btn_confirm → placed = 0.
- reset asserted asynchronously between clk edges while in PLACED → all outputs read 0 before the next clk edge. ship_len = 0 then a btn_y press → L = 1, only cell 0 is non-zero (0x11).
- With SHIP_CURSOR_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16: a 10-cycle glitch on btn_x → no change. A 20-cycle press → one move, visible DEBOUNCE_CYCLES edges later than in the undebounced case.

Source files
------------

// File: rtl/battleship_pkg.sv
// battleship_pkg: shared cursor state encoding, orientation constants and ship length clamp.
package battleship_pkg;
  typedef enum logic [1:0] {HIDDEN, EDIT, PLACED} state_t;
  localparam logic HORIZ = 1'b0;
  localparam logic VERT = 1'b1;
  function automatic int clamp_len(input logic [2:0] len, input int max_len);
    return len == 3'd0 ? 1 : (int'(len) > max_len ? max_len : int'(len));
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-flop synchronizer, optional debounce (SHIP_CURSOR_DEBOUNCE_EN), one-cycle rising-edge pulse.
// The detector only arms once the button has been seen low, so a press held through reset never fires.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);
  logic [1:0] r_sync, r_vld;
  logic r_prev, r_armed, w_level;
`ifdef SHIP_CURSOR_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic r_filt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_filt <= 1'b0;
    end else if (r_sync[1] == r_filt) r_cnt <= '0;
    else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_filt <= r_sync[1];
      r_cnt <= '0;
    end else r_cnt <= r_cnt + CNT_W'(1);
  assign w_level = r_filt;
`else
  assign w_level = r_sync[1];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync <= '0;
      r_vld <= '0;
      r_prev <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_vld <= {r_vld[0], 1'b1};
      r_prev <= w_level;
      r_armed <= r_armed | (r_vld[1] & ~r_sync[1]);
    end
  assign o_pulse = w_level & ~r_prev & r_armed;
endmodule

// File: rtl/ship_cursor_ctrl.sv
// ship_cursor_ctrl: button-driven ship anchor/orientation cursor with placement lock and packed cell bus.
// Debounce is enabled by defining SHIP_CURSOR_DEBOUNCE_EN.
module ship_cursor_ctrl
  import battleship_pkg::*;
#(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int MAX_LEN = 5,
  parameter int COORD_W = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           btn_x,
  input  logic                           btn_y,
  input  logic                           btn_rot,
  input  logic                           btn_confirm,
  input  logic [2:0]                     ship_len,
  output logic [2*COORD_W*MAX_LEN-1:0]   positions,
  output logic                           vertical,
  output logic                           placed,
  output logic                           visible
);
  localparam int CW = 2 * COORD_W;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] GW = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GH = COORD_W'(GRID_H);
  logic w_px, w_py, w_prot, w_pcf;
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bx (.clk(clk), .reset(reset), .i_btn(btn_x), .o_pulse(w_px));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_by (.clk(clk), .reset(reset), .i_btn(btn_y), .o_pulse(w_py));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_br (.clk(clk), .reset(reset), .i_btn(btn_rot), .o_pulse(w_prot));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bc (.clk(clk), .reset(reset), .i_btn(btn_confirm), .o_pulse(w_pcf));
  state_t r_state, w_state;
  logic [COORD_W-1:0] r_x, r_y, r_len, w_x, w_y, w_len, w_hx, w_vy, w_lim_x, w_lim_y;
  logic r_vert, w_vert;
  assign w_hx = GW - r_len + ONE;
  assign w_vy = GH - r_len + ONE;
  assign w_lim_x = r_vert ? GW : w_hx;
  assign w_lim_y = r_vert ? w_vy : GH;
  always_comb begin
    w_state = r_state;
    w_x = r_x;
    w_y = r_y;
    w_vert = r_vert;
    w_len = r_len;
    case (r_state)
      HIDDEN:
        if (w_px | w_py | w_prot) begin
          w_state = EDIT;
          w_x = ONE;
          w_y = ONE;
          w_vert = HORIZ;
          w_len = COORD_W'(clamp_len(ship_len, MAX_LEN));
        end
      EDIT:
        if (w_pcf) w_state = PLACED;
        else if (w_prot) begin
          w_vert = ~r_vert;
          if (r_vert) w_x = r_x > w_hx ? w_hx : r_x;
          else w_y = r_y > w_vy ? w_vy : r_y;
        end
        else if (w_px) w_x = r_x >= w_lim_x ? ONE : r_x + ONE;
        else if (w_py) w_y = r_y >= w_lim_y ? ONE : r_y + ONE;
      PLACED:
        if (w_pcf) w_state = EDIT;
      default: w_state = HIDDEN;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= HIDDEN;
      r_x <= '0;
      r_y <= '0;
      r_len <= '0;
      r_vert <= HORIZ;
      vertical <= 1'b0;
      placed <= 1'b0;
      visible <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x <= w_x;
      r_y <= w_y;
      r_len <= w_len;
      r_vert <= w_vert;
      vertical <= w_vert;
      placed <= w_state == PLACED;
      visible <= w_state != HIDDEN;
    end
  // Cells are built from next-state values so the bus updates in step with the anchor.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cell
    localparam logic [COORD_W-1:0] OFS = COORD_W'(i);
    logic [CW-1:0] r_cell;
    always_ff @(posedge clk or posedge reset)
      if (reset) r_cell <= '0;
      else r_cell <= (w_state != HIDDEN && OFS < w_len) ? {w_y + (w_vert ? OFS : '0), w_x + (w_vert ? '0 : OFS)} : '0;
    assign positions[CW*i +: CW] = r_cell;
  end
endmodule
